vx_writeback_arbiter: RTL

Shares the single GPR writeback port among the execute-unit commit streams (ALU, LSU, CSR, FPU, GPU). It feeds the writeback bus consumed by the GPR stage and the scoreboard. Requesters are served round-robin; multi-beat responses are kept contiguous with an end-of-packet lock. The granted beat is registered onto the writeback bus with one cycle of latency.

---
 rtl/vx_writeback_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/vx_writeback_arbiter.sv
// Round-robin arbiter sharing the GPR writeback port among the commit streams.
// Multi-beat packets hold the grant until their eop beat; the winner is registered onto wb_*.
module vx_writeback_arbiter #(
    parameter int  NUM_REQS    = 5,
    parameter int  NUM_WARPS   = 4,
    parameter int  NUM_THREADS = 4,
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid,
    output logic [NUM_REQS-1:0]                req_ready,
    input  logic [NUM_REQS-1:0]                req_wb,
    input  logic [NUM_REQS*NW_BITS-1:0]        req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]    req_tmask,
    input  logic [NUM_REQS*32-1:0]             req_PC,
    input  logic [NUM_REQS*5-1:0]              req_rd,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]                req_eop,
    output logic                               wb_valid,
    output logic [NW_BITS-1:0]                 wb_wid,
    output logic [NUM_THREADS-1:0]             wb_tmask,
    output logic [31:0]                        wb_PC,
    output logic [4:0]                         wb_rd,
    output logic [NUM_THREADS*32-1:0]          wb_data,
    output logic                               wb_eop,
    output logic [43:0]                        stall_cycles
);
    // state  | meaning
    // IDLE   | round-robin among eligible requesters starting at rr_ptr
    // LOCKED | packet in flight; only owner may be granted until its eop beat
    localparam int RR_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_next;
    logic [RR_BITS-1:0]   rr_ptr, rr_ptr_next;
    logic [RR_BITS-1:0]   owner, owner_next;
    logic [RR_BITS-1:0]   grant_idx;
    logic                 grant_any;
    logic [NUM_REQS-1:0]  eligible;
    logic [NUM_REQS-1:0]  grant;
    logic                 stall_evt;

    logic [NW_BITS-1:0]        wid_arr   [NUM_REQS];
    logic [NUM_THREADS-1:0]    tmask_arr [NUM_REQS];
    logic [31:0]               pc_arr    [NUM_REQS];
    logic [4:0]                rd_arr    [NUM_REQS];
    logic [NUM_THREADS*32-1:0] data_arr  [NUM_REQS];

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_unpack
        assign wid_arr[i]   = req_wid[i*NW_BITS +: NW_BITS];
        assign tmask_arr[i] = req_tmask[i*NUM_THREADS +: NUM_THREADS];
        assign pc_arr[i]    = req_PC[i*32 +: 32];
        assign rd_arr[i]    = req_rd[i*5 +: 5];
        assign data_arr[i]  = req_data[i*NUM_THREADS*32 +: NUM_THREADS*32];
    end

    assign eligible = req_valid & req_wb;

    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (!reset) begin
            if (state == LOCKED) begin
                grant_any = eligible[owner];
                grant_idx = owner;
            end else begin
                // scan from the far end so the requester closest to rr_ptr overwrites last
                for (int k = NUM_REQS - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NUM_REQS) idx = idx - NUM_REQS;
                    if (eligible[idx]) begin
                        grant_any = 1'b1;
                        grant_idx = RR_BITS'(idx);
                    end
                end
            end
        end
    end

    assign grant     = grant_any ? (NUM_REQS'(1) << grant_idx) : '0;
    assign req_ready = grant | (req_valid & ~req_wb);
    assign stall_evt = |(eligible & ~grant);

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner;
        if (grant_any) begin
            if (req_eop[grant_idx]) begin
                state_next  = IDLE;
                rr_ptr_next = (grant_idx == RR_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                state_next = LOCKED;
                owner_next = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            owner  <= owner_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_wid   <= '0;
            wb_tmask <= '0;
            wb_PC    <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
        end else begin
            wb_valid <= grant_any;
            if (grant_any) begin
                wb_wid   <= wid_arr[grant_idx];
                wb_tmask <= tmask_arr[grant_idx];
                wb_PC    <= pc_arr[grant_idx];
                wb_rd    <= rd_arr[grant_idx];
                wb_data  <= data_arr[grant_idx];
                wb_eop   <= req_eop[grant_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall_evt && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
